// File: rtl/bcd_display_scan.sv
// bcd_display_scan: multiplexed 4-digit seven-segment driver for a packed BCD value.
// A load strobe captures the value and the adder carry-out into a hold register.
// A prescaler steps a DIG0..DIG3 scan FSM once every REFRESH_DIV clocks.
// seg, an and dp are registered from the current scan state and hold register.
// All outputs are active-low. err flags any held nibble above 9.
// Optional feature: define BCD_DISP_BLANK_EN to enable leading-zero blanking.
// Blanking is suppressed while the held carry-out is set.
module bcd_display_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic        cout_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        err
);

  localparam int unsigned CntW = 20;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {StDig0, StDig1, StDig2, StDig3} state_e;

  state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic        tick;
  logic [15:0] hold_q;
  logic        cout_q;
  logic        err_q;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;
  logic [3:0]  digit;
  logic        blank;

  // Active-low gfedcba pattern; A..F render as a single dash.
  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick = (cnt_q == CntMax);

  // Prescaler: free-running 0..REFRESH_DIV-1, unaffected by load.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Hold register and error flag, both captured on the load edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (load) begin
      hold_q <= bcd_in;
      cout_q <= cout_in;
      err_q  <= (bcd_in[3:0] > 4'd9) | (bcd_in[7:4] > 4'd9) |
                (bcd_in[11:8] > 4'd9) | (bcd_in[15:12] > 4'd9);
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StDig0;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan FSM next state: advance one digit per prescaler tick.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        StDig0: state_d = StDig1;
        StDig1: state_d = StDig2;
        StDig2: state_d = StDig3;
        StDig3: state_d = StDig0;
        default: state_d = StDig0;
      endcase
    end
  end

  // Digit select and blanking decision for the active slot.
  always_comb begin
    digit = hold_q[3:0];
    blank = 1'b0;
    unique case (state_q)
      StDig0: digit = hold_q[3:0];
      StDig1: digit = hold_q[7:4];
      StDig2: digit = hold_q[11:8];
      StDig3: digit = hold_q[15:12];
      default: digit = hold_q[3:0];
    endcase
`ifdef BCD_DISP_BLANK_EN
    // A slot is blank when it and every higher digit are zero; digit 0 always shows.
    unique case (state_q)
      StDig1: blank = (hold_q[15:4] == 12'h000) & ~cout_q;
      StDig2: blank = (hold_q[15:8] == 8'h00) & ~cout_q;
      StDig3: blank = (hold_q[15:12] == 4'h0) & ~cout_q;
      default: blank = 1'b0;
    endcase
`endif
  end

  // Output next-state: segment code, one-hot-low anode and overflow point.
  always_comb begin
    seg_d = seg_lut(digit);
    dp_d  = ~((state_q == StDig3) & cout_q);
    unique case (state_q)
      StDig0: an_d = 4'b1110;
      StDig1: an_d = 4'b1101;
      StDig2: an_d = 4'b1011;
      StDig3: an_d = 4'b0111;
      default: an_d = 4'b1111;
    endcase
    if (blank) begin
      seg_d = 7'h7F;
      an_d  = 4'b1111;
    end
  end

  // Registered display outputs; reset blanks the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= 7'h7F;
      an_q  <= 4'b1111;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan with REFRESH_DIV=4.
// A cycle model pushes the expected {seg,an,dp,err} for every clock edge into a queue.
// Each test task pops one entry per edge and compares, plus fixed-value slot checks.
module tb_bcd_display_scan;

  localparam int Div = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic        cout_in = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [12:0] sb_q[$];
  logic [12:0] exp_v;

  // Model state.
  int          m_cnt = 0;
  int          m_st = 0;
  logic [15:0] m_hold = 16'h0000;
  logic        m_cout = 1'b0;
  logic        m_err = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  bcd_display_scan #(.REFRESH_DIV(Div)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .bcd_in  (bcd_in),
    .cout_in (cout_in),
    .seg     (seg),
    .an      (an),
    .dp      (dp),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Expected {seg,an,dp} for a scan slot and held value.
  function automatic logic [11:0] disp(input int st, input logic [15:0] h, input logic c);
    logic [15:0] sh;
    logic [6:0]  s;
    logic [3:0]  a;
    logic        d;
    sh = h >> (4 * st);
    s  = seg_tab[sh[3:0]];
    a  = ~(4'b0001 << st);
    d  = !(st == 3 && c);
`ifdef BCD_DISP_BLANK_EN
    if (st != 0 && !c && sh == 16'h0000) begin
      s = 7'h7F;
      a = 4'b1111;
    end
`endif
    return {s, a, d};
  endfunction

  function automatic logic bad_digit(input logic [15:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] t;
      t = v >> (4 * i);
      if (t[3:0] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

  // Cycle model: expected outputs produced by each edge.
  always @(posedge clk) begin
    if (reset) begin
      sb_q.push_back({7'h7F, 4'b1111, 1'b1, 1'b0});
      m_cnt  <= 0;
      m_st   <= 0;
      m_hold <= 16'h0000;
      m_cout <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      sb_q.push_back({disp(m_st, m_hold, m_cout), load ? bad_digit(bcd_in) : m_err});
      m_cnt <= (m_cnt == Div - 1) ? 0 : m_cnt + 1;
      m_st  <= (m_cnt == Div - 1) ? (m_st + 1) % 4 : m_st;
      if (load) begin
        m_hold <= bcd_in;
        m_cout <= cout_in;
        m_err  <= bad_digit(bcd_in);
      end
    end
  end

  task automatic test_reset();
    // reset held with load active must still clear everything
    reset = 1'b1; load = 1'b1; bcd_in = 16'h9A99; cout_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        checks++; errors++; $display("FAIL reset_sb_empty cycle %0d", k);
      end else begin
        exp_v = sb_q.pop_front(); checks++;
        if ({seg, an, dp, err} !== exp_v)
          begin errors++; $display("FAIL reset_model cycle %0d got %h want %h", k,
                                   {seg, an, dp, err}, exp_v); end
      end
      if (k == 1) begin
        checks++;
        if (seg !== 7'h7F || an !== 4'b1111 || dp !== 1'b1 || err !== 1'b0)
          begin errors++; $display("FAIL reset_state got %h/%b/%b/%b want 7f/1111/1/0",
                                   seg, an, dp, err); end
        reset = 1'b0; load = 1'b0; cout_in = 1'b0;
      end
      if (k == 2) begin
        checks++;
        if (seg !== 7'h40 || an !== 4'b1110)
          begin errors++; $display("FAIL first_after_reset got %h/%b want 40/1110", seg, an); end
      end
    end
  endtask

  task automatic test_scan();
    reset = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        checks++; errors++; $display("FAIL scan_sb_empty cycle %0d", k);
      end else begin
        exp_v = sb_q.pop_front(); checks++;
        if ({seg, an, dp, err} !== exp_v)
          begin errors++; $display("FAIL scan_model cycle %0d got %h want %h", k,
                                   {seg, an, dp, err}, exp_v); end
      end
      if (k == 2 || k == 5 || k == 9 || k == 13) begin
        logic [10:0] want;
        want = (k == 2) ? {7'h19, 4'b1110} : (k == 5) ? {7'h30, 4'b1101} :
               (k == 9) ? {7'h24, 4'b1011} : {7'h79, 4'b0111};
        checks++;
        if ({seg, an} !== want || dp !== 1'b1 || err !== 1'b0)
          begin errors++; $display("FAIL scan_slot cycle %0d got %h/%b dp %b err %b want %h",
                                   k, seg, an, dp, err, want); end
      end
      if (k == 0) begin reset = 1'b0; load = 1'b1; bcd_in = 16'h1234; cout_in = 1'b0; end
      if (k == 1) load = 1'b0;
    end
  endtask

  task automatic test_overflow();
    reset = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        checks++; errors++; $display("FAIL ovf_sb_empty cycle %0d", k);
      end else begin
        exp_v = sb_q.pop_front(); checks++;
        if ({seg, an, dp, err} !== exp_v)
          begin errors++; $display("FAIL ovf_model cycle %0d got %h want %h", k,
                                   {seg, an, dp, err}, exp_v); end
      end
      if (k == 13 || k == 16) begin
        checks++;
        if (seg !== 7'h40 || an !== 4'b0111 || dp !== 1'b0)
          begin errors++; $display("FAIL ovf_dig3 cycle %0d got %h/%b dp %b want 40/0111 dp 0",
                                   k, seg, an, dp); end
      end
      if (k == 4 || k == 8 || k == 12) begin
        checks++;
        if (dp !== 1'b1)
          begin errors++; $display("FAIL ovf_dp_other cycle %0d got %b want 1", k, dp); end
      end
      if (k == 0) begin reset = 1'b0; load = 1'b1; bcd_in = 16'h0000; cout_in = 1'b1; end
      if (k == 1) begin load = 1'b0; cout_in = 1'b0; end
    end
  endtask

  task automatic test_invalid();
    reset = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        checks++; errors++; $display("FAIL inv_sb_empty cycle %0d", k);
      end else begin
        exp_v = sb_q.pop_front(); checks++;
        if ({seg, an, dp, err} !== exp_v)
          begin errors++; $display("FAIL inv_model cycle %0d got %h want %h", k,
                                   {seg, an, dp, err}, exp_v); end
      end
      if (k == 1) begin
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL inv_err_set got %b want 1", err); end
      end
      if (k == 9) begin
        checks++;
        if (seg !== 7'h3F || an !== 4'b1011)
          begin errors++; $display("FAIL inv_dash got %h/%b want 3f/1011", seg, an); end
      end
      if (k == 13) begin
        checks++;
        if (seg !== 7'h10 || an !== 4'b0111)
          begin errors++; $display("FAIL inv_dig3 got %h/%b want 10/0111", seg, an); end
      end
      if (k == 15) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL inv_err_clear got %b want 0", err); end
      end
      if (k == 0) begin reset = 1'b0; load = 1'b1; bcd_in = 16'h9A05; end
      if (k == 1) load = 1'b0;
      if (k == 14) begin load = 1'b1; bcd_in = 16'h0005; end
      if (k == 15) load = 1'b0;
    end
  endtask

  task automatic test_blank();
    reset = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        checks++; errors++; $display("FAIL blank_sb_empty cycle %0d", k);
      end else begin
        exp_v = sb_q.pop_front(); checks++;
        if ({seg, an, dp, err} !== exp_v)
          begin errors++; $display("FAIL blank_model cycle %0d got %h want %h", k,
                                   {seg, an, dp, err}, exp_v); end
      end
      if (k == 2) begin
        checks++;
        if (seg !== 7'h12 || an !== 4'b1110)
          begin errors++; $display("FAIL blank_dig0 got %h/%b want 12/1110", seg, an); end
      end
      if (k == 5 || k == 9 || k == 13) begin
        logic [10:0] want;
`ifdef BCD_DISP_BLANK_EN
        want = {7'h7F, 4'b1111};
`else
        want = (k == 5) ? {7'h40, 4'b1101} : (k == 9) ? {7'h40, 4'b1011} : {7'h40, 4'b0111};
`endif
        checks++;
        if ({seg, an} !== want)
          begin errors++; $display("FAIL blank_upper cycle %0d got %h/%b want %h",
                                   k, seg, an, want); end
      end
      if (k == 0) begin reset = 1'b0; load = 1'b1; bcd_in = 16'h0005; cout_in = 1'b0; end
      if (k == 1) load = 1'b0;
    end
  endtask

  task automatic test_boundary();
    reset = 1'b1;
    for (int k = 0; k <= 26; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        checks++; errors++; $display("FAIL bnd_sb_empty cycle %0d", k);
      end else begin
        exp_v = sb_q.pop_front(); checks++;
        if ({seg, an, dp, err} !== exp_v)
          begin errors++; $display("FAIL bnd_model cycle %0d got %h want %h", k,
                                   {seg, an, dp, err}, exp_v); end
      end
      if (k == 16) begin
        checks++;
        if (seg !== 7'h79 || an !== 4'b0111)
          begin errors++; $display("FAIL bnd_before got %h/%b want 79/0111", seg, an); end
      end
      if (k == 17) begin
        checks++;
        if (seg !== 7'h00 || an !== 4'b1110)
          begin errors++; $display("FAIL bnd_load_tick got %h/%b want 00/1110", seg, an); end
      end
      if (k == 25) begin
        checks++;
        if (seg !== 7'h7F || an !== 4'b1111 || dp !== 1'b1 || err !== 1'b0)
          begin errors++; $display("FAIL bnd_reset_mid got %h/%b want 7f/1111", seg, an); end
      end
      if (k == 26) begin
        checks++;
        if (seg !== 7'h40 || an !== 4'b1110)
          begin errors++; $display("FAIL bnd_after_reset got %h/%b want 40/1110", seg, an); end
      end
      if (k == 0) begin reset = 1'b0; load = 1'b1; bcd_in = 16'h1234; cout_in = 1'b0; end
      if (k == 1) load = 1'b0;
      // Edge 16 is the DIG3->DIG0 tick.
      if (k == 15) begin load = 1'b1; bcd_in = 16'h5678; end
      if (k == 16) load = 1'b0;
      // Edges 24..27 sit in DIG2.
      if (k == 24) reset = 1'b1;
      if (k == 25) reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_overflow();
    test_invalid();
    test_blank();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
